max_candidate_scanner: RTL and testbench
========================================

Name: max_candidate_scanner

Overview:
- Bit-serial maximum finder over four unsigned operands. It sits directly upstream of the done checker.
- Each cycle it scans one bit, MSB first, and eliminates candidates that hold 0 where another live candidate holds 1.
- It drives the 4-bit live-candidate mask into the done checker and consumes the checker's done signal to terminate early.
- On completion it reports the index and value of the maximum.

Parameters:
- DATA_WIDTH, 8, width of each operand; must be ≥2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; samples a0..a3
- a0  input  DATA_WIDTH  operand 0
- a1  input  DATA_WIDTH  operand 1
- a2  input  DATA_WIDTH  operand 2
- a3  input  DATA_WIDTH  operand 3
- chk_done  input  1  done checker output, computed combinationally from cand_mask (high when cand_mask has zero or one bits set)
- cand_mask  output  4  registered live-candidate mask; bit i = operand i still live; feeds checker inputs 1..4
- busy  output  1  high in SCAN
- valid  output  1  high in DONE; result stable
- max_idx  output  2  index of the maximum
- max_val  output  DATA_WIDTH  value of the maximum

Behaviour:
- One clock domain. Every register clears asynchronously on rst = 1.
- Reset values:
  - state = IDLE
  - cand_mask = 0000
  - bit_idx = DATA_WIDTH-1
  - operand registers = 0
  - busy = 0, valid = 0, max_idx = 0, max_val = 0
- States: IDLE, SCAN, DONE.
- IDLE:
  - start = 1 → r0..r3 ← a0..a3, cand_mask ← 1111, bit_idx ← DATA_WIDTH-1, next state SCAN.
  - chk_done is ignored in IDLE. The checker reports done on a 0000 mask; this is harmless here.
- SCAN, per edge:
  - If chk_done = 1: go to DONE. Mask and bit_idx are unchanged.
  - Otherwise:
    - ones = cand_mask & {r3[bit_idx], r2[bit_idx], r1[bit_idx], r0[bit_idx]}.
    - If ones ≠ 0, cand_mask ← ones. If ones = 0, the mask is unchanged.
    - If bit_idx = 0: go to DONE. Otherwise bit_idx ← bit_idx-1.
  - The mask never becomes 0000 in SCAN.
  - start is ignored in SCAN and does not resample operands.
- DONE:
  - valid = 1.
  - max_idx = index of the lowest set bit of cand_mask, so ties resolve to the lowest index.
  - max_val = r[max_idx].
  - Outputs hold until start. start in DONE behaves exactly as in IDLE (reload, SCAN); valid drops on that edge.
- busy and valid are decoded from the state register and are never high together.
- Latency, counted in rising edges from the edge that samples start:
  - Full scan (no early exit): valid at edge DATA_WIDTH+1.
  - Early exit: if the mask reaches one bit after processing k bits, valid at edge k+2.
  - The bound is always ≤ DATA_WIDTH+1.
- Reset asserted mid-SCAN or in DONE returns to IDLE immediately without waiting for a clock edge, using the reset values above.
- start and rst both high: rst wins.
- Comparison is unsigned. No arithmetic beyond bit selection; bit_idx is ceil(log2(DATA_WIDTH)) bits wide.

Test Plan (DATA_WIDTH = 8; the bench models chk_done as the done-checker function of cand_mask):
- Early exit: start with a0..a3 = 0x12, 0x80, 0x05, 0x7F → edge1 mask 1111; after edge2 mask 0010, chk_done = 1; after edge3 valid = 1, max_idx = 1, max_val = 0x80, busy = 0.
- Tie: a0..a3 = 0x40, 0xF0, 0xF0, 0x10 → after bit 7, mask = 0110 and stays there; valid at edge 9; max_idx = 1, max_val = 0xF0.
- All equal: all operands 0x55 → mask stays 1111 throughout; valid at edge 9; max_idx = 0, max_val = 0x55.
- All zero: all operands 0x00 → mask stays 1111, chk_done never rises; valid at edge 9; max_idx = 0, max_val = 0x00.
- Reset mid-operation: pulse rst between edges 3 and 4 of a scan → cand_mask = 0000, busy = 0, valid = 0 with no clock edge; a subsequent start runs a clean scan.
- Start handling:
  - start pulsed in SCAN with new operands → ignored; the original result is produced.
  - start in DONE with 0x01, 0x02, 0x03, 0x04 → valid drops on that edge.
  - Expected result: the mask first shows a single bit after the bit-2 edge (0x04 is the only operand with bit 2 set); then max_idx = 3, max_val = 0x04.

Source files
------------

// File: rtl/max_candidate_scanner.sv
// Bit-serial maximum finder over four unsigned operands. Scans MSB first, pruning
// candidates that read 0 where another live candidate reads 1; stops early on chk_done.
module max_candidate_scanner #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] a2,
  input  logic [DATA_WIDTH-1:0] a3,
  input  logic                  chk_done,
  output logic [3:0]            cand_mask,
  output logic                  busy,
  output logic                  valid,
  output logic [1:0]            max_idx,
  output logic [DATA_WIDTH-1:0] max_val
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cand_mask_q, cand_mask_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] r0_q, r1_q, r2_q, r3_q;
  logic [DATA_WIDTH-1:0] r0_d, r1_d, r2_d, r3_d;
  logic [1:0]            max_idx_q, max_idx_d;
  logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic [3:0]            ones_s;

  // Ties resolve to the lowest index, so pick the lowest set bit.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    else           idx = 2'd0;
    return idx;
  endfunction

  always_comb begin
    state_d     = state_q;
    cand_mask_d = cand_mask_q;
    bit_idx_d   = bit_idx_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    max_idx_d   = max_idx_q;
    max_val_d   = max_val_q;
    ones_s      = cand_mask_q & {r3_q[bit_idx_q], r2_q[bit_idx_q], r1_q[bit_idx_q], r0_q[bit_idx_q]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          r0_d        = a0;
          r1_d        = a1;
          r2_d        = a2;
          r3_d        = a3;
          cand_mask_d = 4'b1111;
          bit_idx_d   = LAST_IDX;
          state_d     = SCAN;
        end else begin
          state_d = state_q;
        end
      end
      SCAN: begin
        if (chk_done) begin
          state_d = DONE;
        end else begin
          if (ones_s != 4'b0000) begin
            cand_mask_d = ones_s;
          end else begin
            cand_mask_d = cand_mask_q;
          end
          if (bit_idx_q == {IDX_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
        // Capture the result with the mask that will be held in DONE.
        if (state_d == DONE) begin
          max_idx_d = lowest_set(cand_mask_d);
          case (lowest_set(cand_mask_d))
            2'd0:    max_val_d = r0_q;
            2'd1:    max_val_d = r1_q;
            2'd2:    max_val_d = r2_q;
            2'd3:    max_val_d = r3_q;
            default: max_val_d = r0_q;
          endcase
        end else begin
          max_idx_d = max_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_mask_q <= 4'b0000;
      bit_idx_q   <= LAST_IDX;
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      max_idx_q   <= 2'd0;
      max_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_mask_q <= cand_mask_d;
      bit_idx_q   <= bit_idx_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      max_idx_q   <= max_idx_d;
      max_val_q   <= max_val_d;
    end
  end

  assign cand_mask = cand_mask_q;
  assign busy      = (state_q == SCAN);
  assign valid     = (state_q == DONE);
  assign max_idx   = max_idx_q;
  assign max_val   = max_val_q;

endmodule

// File: tb/tb_max_candidate_scanner.sv
// Directed bench for max_candidate_scanner; chk_done is modelled as the done checker
// (high when the mask has zero or one bits set).
module tb_max_candidate_scanner;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] a0, a1, a2, a3;
  logic          chk_done;
  logic [3:0]    cand_mask;
  logic          busy, valid;
  logic [1:0]    max_idx;
  logic [DW-1:0] max_val;

  int n_cmp = 0;
  int n_err = 0;
  int edges;

  max_candidate_scanner #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .chk_done  (chk_done),
    .cand_mask (cand_mask),
    .busy      (busy),
    .valid     (valid),
    .max_idx   (max_idx),
    .max_val   (max_val)
  );

  assign chk_done = ((cand_mask & (cand_mask - 4'd1)) == 4'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start with operands at a negedge; returns at the negedge after the sampling edge.
  task automatic kick(input logic [DW-1:0] v0, v1, v2, v3);
    a0 = v0; a1 = v1; a2 = v2; a3 = v3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
  endtask

  // Step until valid with a bounded edge budget; edges counts from the start edge.
  task automatic wait_valid();
    while (!valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mask", cand_mask, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_idx", max_idx, 2'd0);
    check("rst_val", max_val, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", {busy, valid}, 2'b00);

    // Early exit
    kick(8'h12, 8'h80, 8'h05, 8'h7F);
    check("ee_e1_mask", cand_mask, 4'b1111);
    check("ee_e1_busy", busy, 1'b1);
    @(negedge clk);
    check("ee_e2_mask", cand_mask, 4'b0010);
    check("ee_e2_done", chk_done, 1'b1);
    @(negedge clk);
    check("ee_e3_valid", valid, 1'b1);
    check("ee_e3_busy", busy, 1'b0);
    check("ee_idx", max_idx, 2'd1);
    check("ee_val", max_val, 8'h80);
    @(negedge clk);
    check("ee_hold_valid", valid, 1'b1);
    check("ee_hold_val", max_val, 8'h80);

    // Tie, with an ignored start in SCAN
    kick(8'h40, 8'hF0, 8'hF0, 8'h10);
    @(negedge clk); edges++;
    check("tie_e2_mask", cand_mask, 4'b0110);
    a0 = 8'hFF; a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
    start = 1'b1;
    @(negedge clk); edges++;
    start = 1'b0;
    check("tie_scan_busy", busy, 1'b1);
    check("tie_e3_mask", cand_mask, 4'b0110);
    wait_valid();
    check("tie_latency", edges, 9);
    check("tie_mask", cand_mask, 4'b0110);
    check("tie_idx", max_idx, 2'd1);
    check("tie_val", max_val, 8'hF0);

    // Start in DONE: reload and restart
    kick(8'h01, 8'h02, 8'h03, 8'h04);
    check("rs_valid_drop", valid, 1'b0);
    check("rs_busy", busy, 1'b1);
    repeat (5) begin @(negedge clk); edges++; end
    check("rs_e6_mask", cand_mask, 4'b1111);
    @(negedge clk); edges++;
    check("rs_e7_mask", cand_mask, 4'b1000);
    wait_valid();
    check("rs_latency", edges, 8);
    check("rs_idx", max_idx, 2'd3);
    check("rs_val", max_val, 8'h04);

    // All equal
    kick(8'h55, 8'h55, 8'h55, 8'h55);
    wait_valid();
    check("eq_latency", edges, 9);
    check("eq_mask", cand_mask, 4'b1111);
    check("eq_idx", max_idx, 2'd0);
    check("eq_val", max_val, 8'h55);

    // All zero
    kick(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk); edges++;
    check("z_e2_done", chk_done, 1'b0);
    wait_valid();
    check("z_latency", edges, 9);
    check("z_mask", cand_mask, 4'b1111);
    check("z_idx", max_idx, 2'd0);
    check("z_val", max_val, 8'h00);

    // Reset between edges 3 and 4 of a scan
    kick(8'hAA, 8'hAA, 8'h0A, 8'hA0);
    @(negedge clk);
    @(negedge clk);
    check("mr_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_mask", cand_mask, 4'b0000);
    check("mr_busy", busy, 1'b0);
    check("mr_valid", valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick(8'h03, 8'h09, 8'h81, 8'h7E);
    wait_valid();
    check("mr_latency", edges, 3);
    check("mr_idx", max_idx, 2'd2);
    check("mr_val", max_val, 8'h81);

    // start and rst together: rst wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sr_busy", busy, 1'b0);
    check("sr_mask", cand_mask, 4'b0000);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
